ysyx_22050710_lsu: RTL and testbench

- Multi-cycle load/store unit sitting on the memory side of the execute stage.
- Accepts one memory op per handshake: ALU-computed address, store data and MemOP size code.
- Drives a valid/ready request/response data-memory port and returns load data already extended to 64 bits in the same MemOP encoding the execute stage uses.
- Replaces single-cycle combinational rdata so that multi-cycle memories and SoC buses can be attached.

---
 rtl/ysyx_22050710_pkg.sv | 32 +++
 rtl/ysyx_22050710_lsu_align.sv | 49 ++++
 rtl/ysyx_22050710_lsu.sv | 164 ++++++++++++++++
 tb/tb_ysyx_22050710_lsu.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050710_pkg.sv
// Shared LSU definitions: MemOP size/extension codes, FSM state encoding and
// the size-to-byte-mask helper used by the lane aligner.
package ysyx_22050710_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LBU = 3'b001;
    localparam logic [2:0] LH  = 3'b010;
    localparam logic [2:0] LHU = 3'b011;
    localparam logic [2:0] LW  = 3'b100;
    localparam logic [2:0] LWU = 3'b101;
    localparam logic [2:0] LD  = 3'b110;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitResp,
        StDone
    } lsu_state_e;

    // Byte-enable pattern for the access size, before shifting to the lane.
    function automatic logic [7:0] size_mask(input logic [2:0] memop);
        logic [7:0] mask;
        case (memop[2:1])
            2'b00:   mask = 8'h01;
            2'b01:   mask = 8'h03;
            2'b10:   mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ysyx_22050710_lsu_align.sv
// Byte-lane aligner: shifts store data/mask to the lane, flags misaligned or
// illegal accesses and right-aligns and extends load data. Purely combinational.
module ysyx_22050710_lsu_align
    import ysyx_22050710_pkg::*;
(
    input  logic [2:0]  i_memop,
    input  logic [2:0]  i_off,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rdata,
    output logic [7:0]  o_wmask,
    output logic [63:0] o_wdata,
    output logic        o_misalign,
    output logic [63:0] o_rdata
);

    logic [5:0]  w_shamt;
    logic [63:0] w_rshift;

    assign w_shamt  = {i_off, 3'b000};
    assign o_wmask  = size_mask(i_memop) << i_off;
    assign o_wdata  = i_wdata << w_shamt;
    assign w_rshift = i_rdata >> w_shamt;

    always_comb begin
        o_misalign = 1'b0;
        case (i_memop)
            LB, LBU: o_misalign = 1'b0;
            LH, LHU: o_misalign = i_off[0];
            LW, LWU: o_misalign = |i_off[1:0];
            LD:      o_misalign = |i_off;
            default: o_misalign = 1'b1;
        endcase
    end

    always_comb begin
        o_rdata = 64'h0;
        case (i_memop)
            LB:      o_rdata = {{56{w_rshift[7]}}, w_rshift[7:0]};
            LBU:     o_rdata = {56'h0, w_rshift[7:0]};
            LH:      o_rdata = {{48{w_rshift[15]}}, w_rshift[15:0]};
            LHU:     o_rdata = {48'h0, w_rshift[15:0]};
            LW:      o_rdata = {{32{w_rshift[31]}}, w_rshift[31:0]};
            LWU:     o_rdata = {32'h0, w_rshift[31:0]};
            LD:      o_rdata = w_rshift;
            default: o_rdata = 64'h0;
        endcase
    end

endmodule

// File: rtl/ysyx_22050710_lsu.sv
// Multi-cycle load/store unit: accepts one op per handshake, drives a valid/ready
// data-memory port and returns extended load data with a registered completion.
module ysyx_22050710_lsu
    import ysyx_22050710_pkg::*;
#(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [63:0]       i_wdata,
    input  logic [2:0]        i_MemOP,
    input  logic              i_MemWr,
    input  logic              i_MemRd,
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wen,
    output logic [63:0]       o_mem_wdata,
    output logic [7:0]        o_mem_wmask,
    input  logic              i_mem_resp_valid,
    input  logic [63:0]       i_mem_rdata,
    output logic              o_valid,
    input  logic              i_wb_ready,
    output logic [63:0]       o_rdata,
    output logic              o_err
);

    lsu_state_e        r_state;
    logic [2:0]        r_memop;
    logic [2:0]        r_off;
    logic              r_is_load;
    logic [31:0]       r_cnt;
    logic              r_mem_req_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_wen;
    logic [63:0]       r_mem_wdata;
    logic [7:0]        r_mem_wmask;
    logic              r_valid;
    logic [63:0]       r_rdata;
    logic              r_err;

    logic              w_idle;
    logic [2:0]        w_memop;
    logic [2:0]        w_off;
    logic [7:0]        w_wmask;
    logic [63:0]       w_wdata;
    logic              w_misalign;
    logic [63:0]       w_rdata_ext;
    logic              w_noop;
    logic              w_bad;
    logic              w_issue_store;
    logic [31:0]       w_cnt_nxt;
    logic              w_timeout;

    assign w_idle = (r_state == StIdle);

    // The aligner checks the incoming op while idle and extends for the captured op later.
    assign w_memop = w_idle ? i_MemOP : r_memop;
    assign w_off   = w_idle ? i_addr[2:0] : r_off;

    ysyx_22050710_lsu_align u_align (
        .i_memop    (w_memop),
        .i_off      (w_off),
        .i_wdata    (i_wdata),
        .i_rdata    (i_mem_rdata),
        .o_wmask    (w_wmask),
        .o_wdata    (w_wdata),
        .o_misalign (w_misalign),
        .o_rdata    (w_rdata_ext)
    );

    assign w_noop        = ~i_MemRd & ~i_MemWr;
    assign w_bad         = (i_MemRd & i_MemWr) | w_misalign;
    assign w_issue_store = i_MemWr & ~w_noop & ~w_bad;
    assign w_cnt_nxt     = r_cnt + 32'd1;
    assign w_timeout     = (TIMEOUT_CYC != 0) && (w_cnt_nxt == TIMEOUT_CYC);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= StIdle;
            r_memop         <= 3'b000;
            r_off           <= 3'b000;
            r_is_load       <= 1'b0;
            r_cnt           <= 32'd0;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wen       <= 1'b0;
            r_mem_wdata     <= 64'h0;
            r_mem_wmask     <= 8'h00;
            r_valid         <= 1'b0;
            r_rdata         <= 64'h0;
            r_err           <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_valid) begin
                        r_memop     <= i_MemOP;
                        r_off       <= i_addr[2:0];
                        r_is_load   <= i_MemRd;
                        r_rdata     <= 64'h0;
                        r_err       <= 1'b0;
                        r_mem_addr  <= {i_addr[ADDR_W-1:3], 3'b000};
                        r_mem_wen   <= w_issue_store;
                        r_mem_wdata <= w_issue_store ? w_wdata : 64'h0;
                        r_mem_wmask <= w_issue_store ? w_wmask : 8'h00;
                        if (w_noop) begin
                            r_valid <= 1'b1;
                            r_state <= StDone;
                        end else if (w_bad) begin
                            r_valid <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_mem_req_valid <= 1'b1;
                            r_state         <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (i_mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= 32'd0;
                        r_state         <= StWaitResp;
                    end
                end
                StWaitResp: begin
                    r_cnt <= w_cnt_nxt;
                    if (i_mem_resp_valid) begin
                        r_rdata <= r_is_load ? w_rdata_ext : 64'h0;
                        r_valid <= 1'b1;
                        r_state <= StDone;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    if (i_wb_ready) begin
                        r_valid <= 1'b0;
                        r_cnt   <= 32'd0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_ready         = w_idle;
    assign o_mem_req_valid = r_mem_req_valid;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_wen       = r_mem_wen;
    assign o_mem_wdata     = r_mem_wdata;
    assign o_mem_wmask     = r_mem_wmask;
    assign o_valid         = r_valid;
    assign o_rdata         = r_rdata;
    assign o_err           = r_err;

endmodule

// File: tb/tb_ysyx_22050710_lsu.sv
// Scoreboard bench for the LSU: expected completions are queued as ops are driven
// and compared when the LSU reports completion.
module tb_ysyx_22050710_lsu;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_LWU = 3'b101;
    localparam logic [2:0] OP_LD  = 3'b110;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [63:0] i_addr = 64'h0;
    logic [63:0] i_wdata = 64'h0;
    logic [2:0]  i_MemOP = 3'b000;
    logic        i_MemWr = 1'b0;
    logic        i_MemRd = 1'b0;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready = 1'b0;
    logic [63:0] o_mem_addr;
    logic        o_mem_wen;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wmask;
    logic        i_mem_resp_valid = 1'b0;
    logic [63:0] i_mem_rdata = 64'h0;
    logic        o_valid;
    logic        i_wb_ready = 1'b0;
    logic [63:0] o_rdata;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    ysyx_22050710_lsu #(
        .ADDR_W      (64),
        .TIMEOUT_CYC (8)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_addr           (i_addr),
        .i_wdata          (i_wdata),
        .i_MemOP          (i_MemOP),
        .i_MemWr          (i_MemWr),
        .i_MemRd          (i_MemRd),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_addr       (o_mem_addr),
        .o_mem_wen        (o_mem_wen),
        .o_mem_wdata      (o_mem_wdata),
        .o_mem_wmask      (o_mem_wmask),
        .i_mem_resp_valid (i_mem_resp_valid),
        .i_mem_rdata      (i_mem_rdata),
        .o_valid          (o_valid),
        .i_wb_ready       (i_wb_ready),
        .o_rdata          (o_rdata),
        .o_err            (o_err)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        bit          saw_req;
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          lat;
    } exp_t;

    typedef struct {
        int          lat;
        int          hs_lat;
        bit          ready_start;
        bit          saw_req;
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        bit          stable;
        bit          busy_ok;
        bit          hold_ok;
        bit          retire_ok;
        bit          timed_out;
        logic [63:0] rdata;
        logic        err;
    } obs_t;

    exp_t exp_q[$];

    // Drives one op from a negedge, plays the memory and writeback sides, and
    // returns what was seen. Latencies count negedges after the accept negedge.
    task automatic run_op(input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [2:0] op, input logic wr, input logic rd,
                          input int req_stall, input bit give_resp,
                          input logic [63:0] rdata, input int wb_stall, output obs_t o);
        int stall_cnt;
        bit hs;
        bit resp_sent;
        o.lat = 0; o.hs_lat = -1; o.saw_req = 0; o.addr = 0; o.wen = 0; o.wdata = 0;
        o.wmask = 0; o.stable = 1; o.busy_ok = 1; o.hold_ok = 1; o.retire_ok = 0;
        o.timed_out = 0; o.rdata = 0; o.err = 0;
        stall_cnt = 0; hs = 0; resp_sent = 0;
        o.ready_start = (o_ready === 1'b1);
        i_addr = addr; i_wdata = wdata; i_MemOP = op; i_MemWr = wr; i_MemRd = rd;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        o.lat = 1;
        while (o_valid !== 1'b1 && o.lat < 100) begin
            i_mem_resp_valid = 1'b0;
            if (o_ready !== 1'b0) o.busy_ok = 0;
            if (o_mem_req_valid === 1'b1) begin
                if (!o.saw_req) begin
                    o.addr = o_mem_addr; o.wen = o_mem_wen;
                    o.wdata = o_mem_wdata; o.wmask = o_mem_wmask;
                end else if (o.addr !== o_mem_addr || o.wen !== o_mem_wen ||
                             o.wdata !== o_mem_wdata || o.wmask !== o_mem_wmask) begin
                    o.stable = 0;
                end
                o.saw_req = 1;
                if (stall_cnt >= req_stall) begin
                    i_mem_req_ready = 1'b1;
                    hs = 1;
                    o.hs_lat = o.lat;
                end else begin
                    i_mem_req_ready = 1'b0;
                    stall_cnt++;
                end
            end else begin
                i_mem_req_ready = 1'b0;
                if (hs && give_resp && !resp_sent) begin
                    i_mem_resp_valid = 1'b1;
                    i_mem_rdata = rdata;
                    resp_sent = 1;
                end
            end
            @(negedge i_clk);
            o.lat++;
        end
        i_mem_req_ready = 1'b0;
        i_mem_resp_valid = 1'b0;
        if (o_valid !== 1'b1) o.timed_out = 1;
        o.rdata = o_rdata;
        o.err = o_err;
        for (int i = 0; i < wb_stall; i++) begin
            @(negedge i_clk);
            if (o_valid !== 1'b1 || o_rdata !== o.rdata || o_err !== o.err || o_ready !== 1'b0)
                o.hold_ok = 0;
        end
        i_wb_ready = 1'b1;
        @(negedge i_clk);
        i_wb_ready = 1'b0;
        o.retire_ok = (o_valid === 1'b0 && o_ready === 1'b1);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        checks += 9;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", o_err); end
        if (o_mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", o_mem_req_valid); end
        if (o_mem_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", o_mem_wen); end
        if (o_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", o_rdata); end
        if (o_mem_wdata !== 64'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", o_mem_wdata); end
        if (o_mem_wmask !== 8'h0) begin errors++; $display("FAIL reset_wmask got %h want 0", o_mem_wmask); end
        if (o_mem_addr !== 64'h0) begin errors++; $display("FAIL reset_addr got %h want 0", o_mem_addr); end
        if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_ready); end
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_load_byte();
        obs_t o;
        exp_t e;
        exp_q.push_back('{rdata: 64'hFFFF_FFFF_FFFF_FFF0, err: 1'b0, saw_req: 1,
                          addr: 64'h8000_0000, wen: 1'b0, wdata: 64'h0, wmask: 8'h00, lat: 3});
        run_op(64'h8000_0003, 64'h0, OP_LB, 1'b0, 1'b1, 0, 1, 64'h0000_0000_F000_0000, 0, o);
        e = exp_q.pop_front();
        checks += 8;
        if (o.rdata !== e.rdata) begin errors++; $display("FAIL lb_rdata got %h want %h", o.rdata, e.rdata); end
        if (o.err !== e.err) begin errors++; $display("FAIL lb_err got %b want %b", o.err, e.err); end
        if (o.lat != e.lat) begin errors++; $display("FAIL lb_latency got %0d want %0d", o.lat, e.lat); end
        if (o.saw_req != e.saw_req) begin errors++; $display("FAIL lb_req got %0d want %0d", o.saw_req, e.saw_req); end
        if (o.addr !== e.addr) begin errors++; $display("FAIL lb_addr got %h want %h", o.addr, e.addr); end
        if (o.wen !== e.wen || o.wmask !== e.wmask || o.wdata !== e.wdata) begin
            errors++;
            $display("FAIL lb_wfields got wen %b mask %h data %h want 0 0 0", o.wen, o.wmask, o.wdata);
        end
        if (!o.busy_ok) begin errors++; $display("FAIL lb_busy got ready high mid-op want low"); end
        if (!o.retire_ok) begin errors++; $display("FAIL lb_retire got busy after wb want idle"); end
    endtask

    task automatic test_store_half();
        obs_t o;
        exp_t e;
        exp_q.push_back('{rdata: 64'h0, err: 1'b0, saw_req: 1, addr: 64'h8000_0000, wen: 1'b1,
                          wdata: 64'hABCD_0000_0000_0000, wmask: 8'hC0, lat: 3});
        run_op(64'h8000_0006, 64'hABCD, OP_LH, 1'b1, 1'b0, 0, 1, 64'h1111_2222_3333_4444, 0, o);
        e = exp_q.pop_front();
        checks += 6;
        if (o.addr !== e.addr) begin errors++; $display("FAIL sh_addr got %h want %h", o.addr, e.addr); end
        if (o.wmask !== e.wmask) begin errors++; $display("FAIL sh_wmask got %h want %h", o.wmask, e.wmask); end
        if (o.wdata !== e.wdata) begin errors++; $display("FAIL sh_wdata got %h want %h", o.wdata, e.wdata); end
        if (o.wen !== e.wen) begin errors++; $display("FAIL sh_wen got %b want %b", o.wen, e.wen); end
        if (o.rdata !== e.rdata) begin errors++; $display("FAIL sh_rdata got %h want %h", o.rdata, e.rdata); end
        if (o.lat != e.lat || o.err !== e.err) begin
            errors++; $display("FAIL sh_done got lat %0d err %b want %0d %b", o.lat, o.err, e.lat, e.err);
        end
    endtask

    // Error and no-op cases complete one cycle after accept without touching memory.
    task automatic test_misaligned();
        logic [63:0] addrs [6];
        logic [2:0]  ops   [6];
        logic        wrs   [6];
        logic        rds   [6];
        logic        errs  [6];
        obs_t o;
        exp_t e;
        addrs = '{64'h8000_0002, 64'h8000_0004, 64'h8000_0001, 64'h8000_0000,
                  64'h8000_0000, 64'h8000_0000};
        ops   = '{OP_LW, OP_LD, OP_LHU, 3'b111, OP_LD, OP_LD};
        wrs   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        rds   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        errs  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{rdata: 64'h0, err: errs[i], saw_req: 0, addr: 64'h0, wen: 1'b0,
                              wdata: 64'h0, wmask: 8'h0, lat: 1});
            run_op(addrs[i], 64'hFFFF_FFFF_FFFF_FFFF, ops[i], wrs[i], rds[i], 0, 1,
                   64'h5555_5555_5555_5555, 0, o);
            e = exp_q.pop_front();
            checks += 4;
            if (o.err !== e.err) begin errors++; $display("FAIL mis%0d_err got %b want %b", i, o.err, e.err); end
            if (o.saw_req != e.saw_req) begin errors++; $display("FAIL mis%0d_req got %0d want 0", i, o.saw_req); end
            if (o.lat != e.lat) begin errors++; $display("FAIL mis%0d_latency got %0d want %0d", i, o.lat, e.lat); end
            if (o.rdata !== e.rdata) begin errors++; $display("FAIL mis%0d_rdata got %h want 0", i, o.rdata); end
        end
    endtask

    task automatic test_loads();
        logic [2:0]  ops  [11];
        logic [2:0]  offs [11];
        logic [63:0] raws [11];
        logic [63:0] exps [11];
        logic [63:0] ra;
        logic [63:0] rb;
        obs_t o;
        exp_t e;
        ra = 64'hF1E2_D3C4_B5A6_9788;
        rb = 64'h7F6E_5D4C_3B2A_1908;
        ops  = '{OP_LBU, OP_LB, OP_LB, OP_LH, OP_LHU, OP_LW, OP_LWU, OP_LD, OP_LW, OP_LB, OP_LH};
        offs = '{3'd1, 3'd5, 3'd0, 3'd2, 3'd6, 3'd4, 3'd0, 3'd0, 3'd4, 3'd2, 3'd6};
        raws = '{ra, ra, ra, ra, ra, ra, ra, ra, rb, rb, rb};
        exps = '{64'h0000_0000_0000_0097, 64'hFFFF_FFFF_FFFF_FFD3, 64'hFFFF_FFFF_FFFF_FF88,
                 64'hFFFF_FFFF_FFFF_B5A6, 64'h0000_0000_0000_F1E2, 64'hFFFF_FFFF_F1E2_D3C4,
                 64'h0000_0000_B5A6_9788, 64'hF1E2_D3C4_B5A6_9788, 64'h0000_0000_7F6E_5D4C,
                 64'h0000_0000_0000_002A, 64'h0000_0000_0000_7F6E};
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back('{rdata: exps[i], err: 1'b0, saw_req: 1, addr: 64'h8000_1000,
                              wen: 1'b0, wdata: 64'h0, wmask: 8'h0, lat: 3});
            run_op(64'h8000_1000 | {61'h0, offs[i]}, 64'h0, ops[i], 1'b0, 1'b1, 0, 1, raws[i], 0, o);
            e = exp_q.pop_front();
            checks += 3;
            if (o.rdata !== e.rdata) begin errors++; $display("FAIL ld%0d_rdata got %h want %h", i, o.rdata, e.rdata); end
            if (o.err !== e.err || o.lat != e.lat) begin
                errors++; $display("FAIL ld%0d_done got err %b lat %0d want 0 3", i, o.err, o.lat);
            end
            if (o.addr !== e.addr || o.wen !== e.wen || o.wmask !== e.wmask) begin
                errors++; $display("FAIL ld%0d_req got addr %h wen %b mask %h want %h 0 0", i, o.addr, o.wen, o.wmask, e.addr);
            end
        end
    endtask

    task automatic test_stores();
        logic [2:0]  ops   [4];
        logic [2:0]  offs  [4];
        logic [63:0] wds   [4];
        logic [63:0] ewd   [4];
        logic [7:0]  emask [4];
        obs_t o;
        exp_t e;
        ops   = '{OP_LB, OP_LW, OP_LD, OP_LHU};
        offs  = '{3'd5, 3'd4, 3'd0, 3'd2};
        wds   = '{64'h5A, 64'hDEAD_BEEF, 64'h0123_4567_89AB_CDEF, 64'h1234};
        ewd   = '{64'h0000_5A00_0000_0000, 64'hDEAD_BEEF_0000_0000, 64'h0123_4567_89AB_CDEF,
                  64'h0000_0000_1234_0000};
        emask = '{8'h20, 8'hF0, 8'hFF, 8'h0C};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{rdata: 64'h0, err: 1'b0, saw_req: 1, addr: 64'h8000_2000,
                              wen: 1'b1, wdata: ewd[i], wmask: emask[i], lat: 3});
            run_op(64'h8000_2000 | {61'h0, offs[i]}, wds[i], ops[i], 1'b1, 1'b0, 0, 1,
                   64'h9999_9999_9999_9999, 0, o);
            e = exp_q.pop_front();
            checks += 4;
            if (o.wmask !== e.wmask) begin errors++; $display("FAIL st%0d_wmask got %h want %h", i, o.wmask, e.wmask); end
            if (o.wdata !== e.wdata) begin errors++; $display("FAIL st%0d_wdata got %h want %h", i, o.wdata, e.wdata); end
            if (o.wen !== e.wen || o.addr !== e.addr) begin
                errors++; $display("FAIL st%0d_req got wen %b addr %h want 1 %h", i, o.wen, o.addr, e.addr);
            end
            if (o.rdata !== e.rdata || o.err !== e.err) begin
                errors++; $display("FAIL st%0d_done got rdata %h err %b want 0 0", i, o.rdata, o.err);
            end
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        exp_t e;
        exp_q.push_back('{rdata: 64'h9876, err: 1'b0, saw_req: 1, addr: 64'h8000_0000, wen: 1'b0,
                          wdata: 64'h0, wmask: 8'h0, lat: 8});
        run_op(64'h8000_0002, 64'h0, OP_LHU, 1'b0, 1'b1, 5, 1, 64'h0000_0000_9876_0000, 3, o);
        e = exp_q.pop_front();
        checks += 6;
        if (!o.stable) begin errors++; $display("FAIL bp_stable got request fields changing want held"); end
        if (!o.busy_ok) begin errors++; $display("FAIL bp_busy got ready high mid-op want low"); end
        if (!o.hold_ok) begin errors++; $display("FAIL bp_hold got completion changing under stall want held"); end
        if (o.rdata !== e.rdata) begin errors++; $display("FAIL bp_rdata got %h want %h", o.rdata, e.rdata); end
        if (o.lat != e.lat) begin errors++; $display("FAIL bp_latency got %0d want %0d", o.lat, e.lat); end
        if (!o.retire_ok) begin errors++; $display("FAIL bp_retire got busy after wb want idle"); end
    endtask

    // Completion register is loaded 8 edges after the handshake edge, seen 9 negedges later.
    task automatic test_timeout();
        obs_t o;
        exp_t e;
        exp_q.push_back('{rdata: 64'h0, err: 1'b1, saw_req: 1, addr: 64'h8000_0010, wen: 1'b0,
                          wdata: 64'h0, wmask: 8'h0, lat: 9});
        run_op(64'h8000_0010, 64'h0, OP_LW, 1'b0, 1'b1, 0, 0, 64'h0, 0, o);
        e = exp_q.pop_front();
        checks += 4;
        if (o.timed_out) begin errors++; $display("FAIL to_bound got no completion want completion"); end
        if (o.err !== e.err) begin errors++; $display("FAIL to_err got %b want %b", o.err, e.err); end
        if (o.lat - o.hs_lat != e.lat) begin
            errors++; $display("FAIL to_latency got %0d want %0d", o.lat - o.hs_lat, e.lat);
        end
        if (o.saw_req != e.saw_req) begin errors++; $display("FAIL to_req got %0d want 1", o.saw_req); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        exp_t e;
        i_addr = 64'h8000_0008; i_MemOP = OP_LD; i_MemRd = 1'b1; i_MemWr = 1'b0;
        i_valid = 1'b1; i_mem_req_ready = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        i_mem_req_ready = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        checks += 4;
        if (o_mem_addr !== 64'h0) begin errors++; $display("FAIL rm_addr got %h want 0", o_mem_addr); end
        if (o_valid !== 1'b0 || o_err !== 1'b0) begin
            errors++; $display("FAIL rm_done got valid %b err %b want 0 0", o_valid, o_err);
        end
        if (o_mem_req_valid !== 1'b0 || o_mem_wen !== 1'b0 || o_mem_wmask !== 8'h0 ||
            o_mem_wdata !== 64'h0 || o_rdata !== 64'h0) begin
            errors++; $display("FAIL rm_outs got req %b wen %b mask %h wdata %h rdata %h want all 0",
                               o_mem_req_valid, o_mem_wen, o_mem_wmask, o_mem_wdata, o_rdata);
        end
        if (o_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b want 1", o_ready); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_mem_resp_valid = 1'b1;
        i_mem_rdata = 64'h7777_7777_7777_7777;
        @(negedge i_clk);
        i_mem_resp_valid = 1'b0;
        checks += 1;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL rm_late_resp got valid %b ready %b want 0 1", o_valid, o_ready);
        end
        exp_q.push_back('{rdata: 64'h0000_0000_8000_0001, err: 1'b0, saw_req: 1, addr: 64'h8000_0000,
                          wen: 1'b0, wdata: 64'h0, wmask: 8'h0, lat: 3});
        run_op(64'h8000_0004, 64'h0, OP_LWU, 1'b0, 1'b1, 0, 1, 64'h8000_0001_1234_5678, 0, o);
        e = exp_q.pop_front();
        checks += 2;
        if (o.rdata !== e.rdata) begin errors++; $display("FAIL rm_next_rdata got %h want %h", o.rdata, e.rdata); end
        if (o.lat != e.lat || o.err !== e.err) begin
            errors++; $display("FAIL rm_next_done got lat %0d err %b want 3 0", o.lat, o.err);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        exp_q.push_back('{rdata: 64'h0000_0000_0000_0042, err: 1'b0, saw_req: 1, addr: 64'h8000_3000,
                          wen: 1'b0, wdata: 64'h0, wmask: 8'h0, lat: 3});
        exp_q.push_back('{rdata: 64'h0, err: 1'b0, saw_req: 1, addr: 64'h8000_3000, wen: 1'b1,
                          wdata: 64'h0000_0000_CAFE_F00D, wmask: 8'h0F, lat: 3});
        run_op(64'h8000_3007, 64'h0, OP_LBU, 1'b0, 1'b1, 0, 1, 64'h4200_0000_0000_0000, 0, o);
        e = exp_q.pop_front();
        checks += 1;
        if (o.rdata !== e.rdata || o.lat != e.lat) begin
            errors++; $display("FAIL b2b_first got rdata %h lat %0d want %h %0d", o.rdata, o.lat, e.rdata, e.lat);
        end
        run_op(64'h8000_3000, 64'hCAFE_F00D, OP_LWU, 1'b1, 1'b0, 0, 1, 64'h0, 0, o);
        e = exp_q.pop_front();
        checks += 3;
        if (!o.ready_start) begin errors++; $display("FAIL b2b_ready got 0 want 1"); end
        if (o.wdata !== e.wdata || o.wmask !== e.wmask || o.wen !== e.wen) begin
            errors++; $display("FAIL b2b_store got data %h mask %h wen %b want %h %h 1", o.wdata, o.wmask, o.wen, e.wdata, e.wmask);
        end
        if (o.lat != e.lat) begin errors++; $display("FAIL b2b_latency got %0d want %0d", o.lat, e.lat); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_loads();
        test_stores();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
